// File: rtl/brl_shift_ctrl.sv
// brl_shift_ctrl: sequences a 32-bit rotate/shift through a shared barrel
// rotate-left unit that can only rotate by 0..15 per pass. Right shifts are
// mapped onto an equivalent left rotate, and the result is then masked (or
// sign-filled) in a final cycle to turn the rotate into a shift.
module brl_shift_ctrl #(
    parameter int DATA_W   = 32,
    parameter int STEP_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [4:0]        i_amt,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_brl,
    output logic [DATA_W-1:0] o_brl_b,
    output logic [3:0]        o_brl_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);

    // Operation encodings: bit 1 set means a right shift (rotate the other way).
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    localparam logic [4:0]        STEP_LIM = 5'(STEP_MAX);
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        amt_q, amt_d;
    logic [1:0]        op_q, op_d;
    logic              sign_q, sign_d;
    logic [4:0]        rem_q, rem_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [3:0]        sel_s;
    logic [4:0]        rot_s;
    logic [DATA_W-1:0] masked_s;
    logic [DATA_W-1:0] keep_lo_s;
    logic [DATA_W-1:0] keep_hi_s;

    // Per-pass rotate select: largest step the barrel unit allows, only while rotating.
    always_comb begin
        sel_s = 4'd0;
        if (state_q == ST_ROT) begin
            if (rem_q > STEP_LIM) begin
                sel_s = STEP_LIM[3:0];
            end else begin
                sel_s = rem_q[3:0];
            end
        end else begin
            sel_s = 4'd0;
        end
    end

    // Effective left rotate for a new request: right shifts rotate by (32-n) mod 32.
    always_comb begin
        rot_s = 5'd0;
        if (i_op[1]) begin
            rot_s = 5'd0 - i_amt;
        end else begin
            rot_s = i_amt;
        end
    end

    // Fill mask turning the rotated accumulator into a shift result; n=0 keeps all bits.
    always_comb begin
        keep_lo_s = ALL_ONES << amt_q;
        keep_hi_s = ALL_ONES >> amt_q;
        masked_s  = acc_q;
        case (op_q)
            OP_ROL:  masked_s = acc_q;
            OP_SLL:  masked_s = acc_q & keep_lo_s;
            OP_SRL:  masked_s = acc_q & keep_hi_s;
            OP_SRA:  masked_s = (acc_q & keep_hi_s) | ({DATA_W{sign_q}} & ~keep_hi_s);
            default: masked_s = acc_q;
        endcase
    end

    // Next-state logic: accept in IDLE, one barrel pass per ROT cycle, finish in FIN.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        amt_d    = amt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    acc_d  = i_data;
                    amt_d  = i_amt;
                    op_d   = i_op;
                    sign_d = i_data[DATA_W-1];
                    rem_d  = rot_s;
                    if (rot_s != 5'd0) begin
                        state_d = ST_ROT;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROT: begin
                acc_d = i_brl;
                rem_d = rem_q - {1'b0, sel_s};
                if (rem_d == 5'd0) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_ROT;
                end
            end
            ST_FIN: begin
                result_d = masked_s;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without a done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= {DATA_W{1'b0}};
            amt_q    <= 5'd0;
            op_q     <= 2'b00;
            sign_q   <= 1'b0;
            rem_q    <= 5'd0;
            done_q   <= 1'b0;
            result_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign o_brl_b   = acc_q;
    assign o_brl_sel = sel_s;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done_q;
    assign o_result  = result_q;

endmodule

// File: tb/tb_brl_shift_ctrl.sv
// Directed testbench for brl_shift_ctrl with a behavioural barrel rotate-left unit.
`timescale 1ns/1ps
module tb_brl_shift_ctrl;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [31:0] brl;
    logic [31:0] brl_b;
    logic [3:0]  brl_sel;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [63:0] dbl;

    int          n_checks;
    int          n_fail;
    logic [3:0]  sel_log[$];

    brl_shift_ctrl #(.DATA_W(32), .STEP_MAX(15)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_data    (data),
        .i_amt     (amt),
        .i_op      (op),
        .i_brl     (brl),
        .o_brl_b   (brl_b),
        .o_brl_sel (brl_sel),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result)
    );

    // Barrel unit model: rotate left by 0..15.
    assign dbl = {brl_b, brl_b} << brl_sel;
    assign brl = dbl[63:32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; returns #1 after the accepting edge with the select log cleared.
    task automatic issue(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
        @(posedge clk);
        #1;
        data  = d;
        amt   = a;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel_log.delete();
    endtask

    // Advance until o_done is seen (bounded); k counts edges since the accepting edge.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 40) begin
            if (brl_sel != 4'd0) sel_log.push_back(brl_sel);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        data  = 32'h0;
        amt   = 5'd0;
        op    = 2'b00;
        #12;
        n_checks++;
        if ({busy, done, brl_sel, brl_b, result} !== 70'h0) begin
            $display("FAIL reset_state: busy=%b done=%b sel=%0d b=%h result=%h, expected all zero",
                     busy, done, brl_sel, brl_b, result);
            n_fail++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
            n_fail++;
        end
    endtask

    task automatic test_rol();
        int k;
        issue(32'h8000_0001, 5'd1, OP_ROL);
        n_checks++;
        if (brl_b !== 32'h8000_0001 || busy !== 1'b1) begin
            $display("FAIL rol1_operand: b=%h busy=%b, expected 80000001 1", brl_b, busy);
            n_fail++;
        end
        wait_done(0, k);
        n_checks++;
        if (k !== 2 || sel_log.size() !== 1 || sel_log[0] !== 4'd1) begin
            $display("FAIL rol1_timing: latency=%0d passes=%0d, expected 2 with sel 1", k, sel_log.size());
            n_fail++;
        end
        n_checks++;
        if (result !== 32'h0000_0003) begin
            $display("FAIL rol1_result: got %h, expected 00000003", result);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || result !== 32'h0000_0003) begin
            $display("FAIL rol1_pulse_hold: done=%b result=%h, expected 0 00000003", done, result);
            n_fail++;
        end
        issue(32'h1234_5678, 5'd31, OP_ROL);
        wait_done(0, k);
        n_checks++;
        if (k !== 4 || sel_log.size() !== 3 || sel_log[0] !== 4'd15 || sel_log[1] !== 4'd15 || sel_log[2] !== 4'd1) begin
            $display("FAIL rol31_timing: latency=%0d passes=%0d, expected 4 with sel 15,15,1", k, sel_log.size());
            n_fail++;
        end
        n_checks++;
        if (result !== 32'h091A_2B3C) begin
            $display("FAIL rol31_result: got %h, expected 091a2b3c", result);
            n_fail++;
        end
    endtask

    task automatic test_shift_right();
        int k;
        issue(32'h8000_0000, 5'd4, OP_SRA);
        wait_done(0, k);
        n_checks++;
        if (k !== 3 || sel_log.size() !== 2 || sel_log[0] !== 4'd15 || sel_log[1] !== 4'd13) begin
            $display("FAIL sra4_timing: latency=%0d passes=%0d, expected 3 with sel 15,13", k, sel_log.size());
            n_fail++;
        end
        n_checks++;
        if (result !== 32'hF800_0000) begin
            $display("FAIL sra4_result: got %h, expected f8000000", result);
            n_fail++;
        end
        issue(32'hF000_0000, 5'd28, OP_SRL);
        wait_done(0, k);
        n_checks++;
        if (k !== 2 || result !== 32'h0000_000F) begin
            $display("FAIL srl28_result: latency=%0d got %h, expected 2 0000000f", k, result);
            n_fail++;
        end
        issue(32'h7000_0000, 5'd4, OP_SRA);
        wait_done(0, k);
        n_checks++;
        if (result !== 32'h0700_0000) begin
            $display("FAIL sra4_positive: got %h, expected 07000000", result);
            n_fail++;
        end
    endtask

    task automatic test_shift_left();
        int k;
        issue(32'hFFFF_FFFF, 5'd0, OP_SLL);
        wait_done(0, k);
        n_checks++;
        if (k !== 1 || sel_log.size() !== 0 || result !== 32'hFFFF_FFFF) begin
            $display("FAIL sll0: latency=%0d passes=%0d got %h, expected 1 0 ffffffff", k, sel_log.size(), result);
            n_fail++;
        end
        issue(32'h0000_FFFF, 5'd16, OP_SLL);
        wait_done(0, k);
        n_checks++;
        if (k !== 3 || sel_log.size() !== 2 || sel_log[0] !== 4'd15 || sel_log[1] !== 4'd1) begin
            $display("FAIL sll16_timing: latency=%0d passes=%0d, expected 3 with sel 15,1", k, sel_log.size());
            n_fail++;
        end
        n_checks++;
        if (result !== 32'hFFFF_0000) begin
            $display("FAIL sll16_result: got %h, expected ffff0000", result);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int k;
        issue(32'h1234_5678, 5'd31, OP_ROL);
        @(posedge clk);
        #1;
        data  = 32'hDEAD_BEEF;
        amt   = 5'd3;
        op    = OP_SLL;
        start = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_in_rot: got %b, expected 1", busy);
            n_fail++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, k);
        n_checks++;
        if (k !== 4 || result !== 32'h091A_2B3C) begin
            $display("FAIL ignore_start: latency=%0d got %h, expected 4 091a2b3c", k, result);
            n_fail++;
        end
        data  = 32'h0000_0001;
        amt   = 5'd4;
        op    = OP_ROL;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_accept: done=%b busy=%b, expected 0 1", done, busy);
            n_fail++;
        end
        wait_done(0, k);
        n_checks++;
        if (k !== 2 || result !== 32'h0000_0010) begin
            $display("FAIL b2b_result: latency=%0d got %h, expected 2 00000010", k, result);
            n_fail++;
        end
    endtask

    task automatic test_reset_abort();
        int k;
        int stray;
        issue(32'h1234_5678, 5'd1, OP_SRL);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, brl_sel, brl_b, result} !== 70'h0) begin
            $display("FAIL abort_state: busy=%b done=%b sel=%0d b=%h result=%h, expected all zero",
                     busy, done, brl_sel, brl_b, result);
            n_fail++;
        end
        #2;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            $display("FAIL abort_idle: %0d cycles with done/busy set, expected 0", stray);
            n_fail++;
        end
        issue(32'h0000_0001, 5'd0, OP_ROL);
        wait_done(0, k);
        n_checks++;
        if (k !== 1 || result !== 32'h0000_0001) begin
            $display("FAIL after_abort: latency=%0d got %h, expected 1 00000001", k, result);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rol();
        test_shift_right();
        test_shift_left();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
